// File: rtl/execute_pipe_if.sv
// execute_pipe_if: operand/handshake bundle between operand fetch, the
// execute stage and memory access. The master side offers operations and
// consumes results; the slave side (execute_pipe) accepts and produces them.
interface execute_pipe_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [3:0]      alu_control;
  logic [XLEN-1:0] pc_address;
  logic [XLEN-1:0] imm;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] alu_res_out;
  logic [XLEN-1:0] pc_plus_step;
  logic [XLEN-1:0] branch_target;
  logic            busy;

  modport master (
    output in_valid, a, b, alu_control, pc_address, imm, out_ready,
    input  in_ready, out_valid, alu_res_out, pc_plus_step, branch_target, busy
  );

  modport slave (
    input  in_valid, a, b, alu_control, pc_address, imm, out_ready,
    output in_ready, out_valid, alu_res_out, pc_plus_step, branch_target, busy
  );
endinterface

// File: rtl/execute_pipe.sv
// execute_pipe: registered, handshaked RV32I execute stage.
// Produces ALU result, pc + PC_STEP and pc + imm into an output register
// that holds under backpressure.
// Optional feature macro EXEC_MULDIV_EN: when defined, codes A-D
// (MUL, MULHU, DIVU, REMU) run on an iterative one-bit-per-cycle engine
// taking XLEN cycles plus one result-register cycle; when undefined those
// codes return 0 in a single cycle and no engine is built.
module execute_pipe #(
  parameter int XLEN    = 32,
  parameter int PC_STEP = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  execute_pipe_if.slave  bus
);

  localparam int SW = $clog2(XLEN);

`ifdef EXEC_MULDIV_EN
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_e;
  localparam int CW = $clog2(XLEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN);
`else
  typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_e;
`endif

  state_e          state_q, state_d;
  logic [XLEN-1:0] res_q, res_d;
  logic [XLEN-1:0] pcs_q, pcs_d;
  logic [XLEN-1:0] bt_q, bt_d;

  logic            in_ready_c;
  logic            take;
  logic [XLEN-1:0] alu_res;
  logic [SW-1:0]   shamt;

`ifdef EXEC_MULDIV_EN
  // acc holds the product high half / partial remainder,
  // qr holds the product low half (multiplier) / quotient (dividend).
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] qr_q, qr_d;
  logic [XLEN-1:0] opb_q, opb_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            div_q, div_d;
  logic            sel_q, sel_d;
  logic            is_multi;
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;
  logic [XLEN-1:0] div_diff;
  logic            div_ge;
`endif

  // Single-cycle ALU on the offered operands
  always_comb begin
    alu_res = '0;
    shamt   = bus.b[SW-1:0];
    case (bus.alu_control)
      4'h0: alu_res = bus.a + bus.b;
      4'h1: alu_res = bus.a - bus.b;
      4'h2: alu_res = bus.a << shamt;
      4'h3: alu_res = {{(XLEN-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      4'h4: alu_res = {{(XLEN-1){1'b0}}, (bus.a < bus.b)};
      4'h5: alu_res = bus.a ^ bus.b;
      4'h6: alu_res = bus.a >> shamt;
      4'h7: alu_res = $signed(bus.a) >>> shamt;
      4'h8: alu_res = bus.a | bus.b;
      4'h9: alu_res = bus.a & bus.b;
      default: alu_res = '0;
    endcase
  end

`ifdef EXEC_MULDIV_EN
  // One iteration of shift-add multiply and restoring divide
  always_comb begin
    is_multi  = (bus.alu_control >= 4'hA) && (bus.alu_control <= 4'hD);
    mul_sum   = {1'b0, acc_q} + (qr_q[0] ? {1'b0, opb_q} : '0);
    div_shift = {acc_q, qr_q[XLEN-1]};
    div_ge    = div_shift >= {1'b0, opb_q};
    // when the subtract succeeds the remainder is below the divisor, so the
    // low XLEN bits of the difference are exact
    div_diff  = div_shift[XLEN-1:0] - opb_q;
  end
`endif

  // Handshake, next-state and output-register update
  always_comb begin
    in_ready_c = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
    take       = bus.in_valid && in_ready_c;
    state_d    = state_q;
    res_d      = res_q;
    pcs_d      = pcs_q;
    bt_d       = bt_q;
`ifdef EXEC_MULDIV_EN
    acc_d = acc_q;
    qr_d  = qr_q;
    opb_d = opb_q;
    cnt_d = cnt_q;
    div_d = div_q;
    sel_d = sel_q;
    if (state_q == BUSY) begin
      if (cnt_q == CNT_LAST) begin
        res_d   = sel_q ? acc_q : qr_q;
        state_d = DONE;
      end else begin
        cnt_d = cnt_q + 1'b1;
        if (div_q) begin
          acc_d = div_ge ? div_diff : div_shift[XLEN-1:0];
          qr_d  = {qr_q[XLEN-2:0], div_ge};
        end else begin
          acc_d = mul_sum[XLEN:1];
          qr_d  = {mul_sum[0], qr_q[XLEN-1:1]};
        end
      end
    end else
`endif
    begin
      if (take) begin
        pcs_d = bus.pc_address + XLEN'(PC_STEP);
        bt_d  = bus.pc_address + bus.imm;
`ifdef EXEC_MULDIV_EN
        if (is_multi) begin
          acc_d   = '0;
          qr_d    = bus.a;
          opb_d   = bus.b;
          cnt_d   = '0;
          div_d   = bus.alu_control[2];
          sel_d   = bus.alu_control[0];
          state_d = BUSY;
        end else
`endif
        begin
          res_d   = alu_res;
          state_d = DONE;
        end
      end else if ((state_q == DONE) && bus.out_ready) begin
        state_d = IDLE;
      end
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      res_q   <= '0;
      pcs_q   <= '0;
      bt_q    <= '0;
`ifdef EXEC_MULDIV_EN
      acc_q <= '0;
      qr_q  <= '0;
      opb_q <= '0;
      cnt_q <= '0;
      div_q <= 1'b0;
      sel_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      pcs_q   <= pcs_d;
      bt_q    <= bt_d;
`ifdef EXEC_MULDIV_EN
      acc_q <= acc_d;
      qr_q  <= qr_d;
      opb_q <= opb_d;
      cnt_q <= cnt_d;
      div_q <= div_d;
      sel_q <= sel_d;
`endif
    end
  end

  assign bus.in_ready      = in_ready_c;
  assign bus.out_valid     = (state_q == DONE);
  assign bus.alu_res_out   = res_q;
  assign bus.pc_plus_step  = pcs_q;
  assign bus.branch_target = bt_q;
`ifdef EXEC_MULDIV_EN
  // the final BUSY cycle only registers the result; iteration is over
  assign bus.busy = (state_q == BUSY) && (cnt_q != CNT_LAST);
`else
  assign bus.busy = 1'b0;
`endif

endmodule

// File: tb/tb_execute_pipe.sv
// tb_execute_pipe: directed tests for execute_pipe with hand-computed results.
// Build with +define+EXEC_MULDIV_EN to exercise the multiply/divide engine.
module tb_execute_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  execute_pipe_if #(.XLEN(32)) bus ();

  execute_pipe #(.XLEN(32), .PC_STEP(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] pc, input logic [31:0] imm);
    bus.in_valid    = 1'b1;
    bus.alu_control = op;
    bus.a           = a;
    bus.b           = b;
    bus.pc_address  = pc;
    bus.imm         = imm;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.alu_control = 4'h0; bus.a = '0; bus.b = '0;
    bus.pc_address = '0; bus.imm = '0; bus.out_ready = 1'b1;
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    // something in flight, then reset mid-cycle
    drive(4'h0, 32'd1, 32'd2, 32'h40, 32'h8);
    tick();
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got %h want 0", bus.out_valid); end
    n_vec++; if (bus.alu_res_out !== 32'h0) begin n_err++; $display("FAIL rst_alu_res got %h want 0", bus.alu_res_out); end
    n_vec++; if (bus.pc_plus_step !== 32'h0) begin n_err++; $display("FAIL rst_pc_plus_step got %h want 0", bus.pc_plus_step); end
    n_vec++; if (bus.branch_target !== 32'h0) begin n_err++; $display("FAIL rst_branch_target got %h want 0", bus.branch_target); end
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %h want 0", bus.busy); end
    tick();
    rst_n = 1'b1;
    #1;
    n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready got %h want 1", bus.in_ready); end
    drive(4'h0, 32'd5, 32'd7, 32'h100, 32'h20);
    tick();
    bus.in_valid = 1'b0;
    n_vec++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL add_valid got %h want 1", bus.out_valid); end
    n_vec++; if (bus.alu_res_out !== 32'd12) begin n_err++; $display("FAIL add_res got %h want 0000000c", bus.alu_res_out); end
    n_vec++; if (bus.pc_plus_step !== 32'h104) begin n_err++; $display("FAIL add_pcs got %h want 00000104", bus.pc_plus_step); end
    n_vec++; if (bus.branch_target !== 32'h120) begin n_err++; $display("FAIL add_bt got %h want 00000120", bus.branch_target); end
    tick();
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL add_drain got %h want 0", bus.out_valid); end
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b1;
    drive(4'h1, 32'd3, 32'd5, 32'h200, 32'h10);
    tick();
    n_vec++; if (bus.alu_res_out !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL b2b_sub got %h want fffffffe", bus.alu_res_out); end
    n_vec++; if (bus.branch_target !== 32'h210) begin n_err++; $display("FAIL b2b_sub_bt got %h want 00000210", bus.branch_target); end
    drive(4'h7, 32'h8000_0000, 32'd4, 32'h204, 32'h0);
    tick();
    n_vec++; if (bus.alu_res_out !== 32'hF800_0000) begin n_err++; $display("FAIL b2b_sra got %h want f8000000", bus.alu_res_out); end
    n_vec++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_sra_valid got %h want 1", bus.out_valid); end
    drive(4'h4, 32'd1, 32'd2, 32'h208, 32'h0);
    tick();
    n_vec++; if (bus.alu_res_out !== 32'd1) begin n_err++; $display("FAIL b2b_sltu got %h want 00000001", bus.alu_res_out); end
    n_vec++; if (bus.pc_plus_step !== 32'h20C) begin n_err++; $display("FAIL b2b_sltu_pcs got %h want 0000020c", bus.pc_plus_step); end
    bus.in_valid = 1'b0;
    tick();
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drain got %h want 0", bus.out_valid); end
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    drive(4'h5, 32'hFF, 32'h0F, 32'h300, 32'hFFFF_FFF0);
    tick();
    drive(4'h0, 32'd1, 32'd1, 32'h400, 32'h4);
    for (int i = 0; i < 5; i++) begin
      n_vec++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid[%0d] got %h want 1", i, bus.out_valid); end
      n_vec++; if (bus.alu_res_out !== 32'hF0) begin n_err++; $display("FAIL bp_res[%0d] got %h want 000000f0", i, bus.alu_res_out); end
      n_vec++; if (bus.branch_target !== 32'h2F0) begin n_err++; $display("FAIL bp_bt[%0d] got %h want 000002f0", i, bus.branch_target); end
      n_vec++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready[%0d] got %h want 0", i, bus.in_ready); end
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready got %h want 1", bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    n_vec++; if (bus.alu_res_out !== 32'd2) begin n_err++; $display("FAIL bp_next_res got %h want 00000002", bus.alu_res_out); end
    n_vec++; if (bus.pc_plus_step !== 32'h404) begin n_err++; $display("FAIL bp_next_pcs got %h want 00000404", bus.pc_plus_step); end
    tick();
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drain got %h want 0", bus.out_valid); end
  endtask

  task automatic test_misc();
    logic [3:0]  ops [4] = '{4'h3, 4'h2, 4'hE, 4'h9};
    logic [31:0] av  [4] = '{32'hFFFF_FFFF, 32'd1, 32'd5, 32'hF0F0_1234};
    logic [31:0] bv  [4] = '{32'd1, 32'd35, 32'd5, 32'h0FF0_FF00};
    logic [31:0] ev  [4] = '{32'd1, 32'd8, 32'd0, 32'h00F0_1200};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(ops[i], av[i], bv[i], 32'h600, 32'h0);
      tick();
      n_vec++; if (bus.alu_res_out !== ev[i]) begin n_err++; $display("FAIL misc_op%h got %h want %h", ops[i], bus.alu_res_out, ev[i]); end
    end
    bus.in_valid = 1'b0;
    tick();
  endtask

`ifdef EXEC_MULDIV_EN
  task automatic run_multi(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp, input string name);
    int unsigned busy_n;
    int unsigned k;
    bit got;
    bit ready_err;
    bus.out_ready = 1'b1;
    drive(op, a, b, 32'h500, 32'h8);
    #1;
    n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL %s_accept got %h want 1", name, bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    bus.a = $urandom;
    bus.b = $urandom;
    busy_n = bus.busy ? 1 : 0;
    got = 1'b0; k = 0; ready_err = 1'b0;
    for (int i = 1; i <= 40 && !got; i++) begin
      tick();
      if (bus.busy) busy_n++;
      if (bus.out_valid) begin got = 1'b1; k = i; end
      else if (bus.in_ready) ready_err = 1'b1;
    end
    n_vec++; if (!got) begin n_err++; $display("FAIL %s_timeout got no out_valid want within 40", name); end
    n_vec++; if (k != 33) begin n_err++; $display("FAIL %s_latency got %0d want 33", name, k); end
    n_vec++; if (busy_n != 32) begin n_err++; $display("FAIL %s_busy_cycles got %0d want 32", name, busy_n); end
    n_vec++; if (ready_err) begin n_err++; $display("FAIL %s_in_ready_busy got 1 want 0", name); end
    n_vec++; if (bus.alu_res_out !== exp) begin n_err++; $display("FAIL %s_res got %h want %h", name, bus.alu_res_out, exp); end
    n_vec++; if (bus.pc_plus_step !== 32'h504) begin n_err++; $display("FAIL %s_pcs got %h want 00000504", name, bus.pc_plus_step); end
  endtask

  task automatic test_muldiv();
    run_multi(4'hA, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, "mul");
    run_multi(4'hB, 32'hFFFF_FFFF, 32'd2, 32'd1, "mulhu");
    run_multi(4'hC, 32'd100, 32'd7, 32'd14, "divu");
    run_multi(4'hD, 32'd100, 32'd7, 32'd2, "remu");
    run_multi(4'hC, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, "divu0");
    run_multi(4'hD, 32'd9, 32'd0, 32'd9, "remu0");
    bus.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_busy();
    bit seen;
    drive(4'hA, 32'd6, 32'd7, 32'h700, 32'h0);
    tick();
    bus.in_valid = 1'b0;
    repeat (10) tick();
    n_vec++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL rb_busy got %h want 1", bus.busy); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rb_busy_cleared got %h want 0", bus.busy); end
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      tick();
      if (bus.out_valid) seen = 1'b1;
    end
    n_vec++; if (seen) begin n_err++; $display("FAIL rb_no_output got out_valid want none"); end
  endtask
`else
  task automatic test_no_muldiv();
    bit busy_seen;
    bus.out_ready = 1'b1;
    busy_seen = 1'b0;
    drive(4'hA, 32'd3, 32'd4, 32'h800, 32'h0);
    tick();
    bus.in_valid = 1'b0;
    if (bus.busy) busy_seen = 1'b1;
    n_vec++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL nomd_valid got %h want 1", bus.out_valid); end
    n_vec++; if (bus.alu_res_out !== 32'd0) begin n_err++; $display("FAIL nomd_res got %h want 00000000", bus.alu_res_out); end
    tick();
    if (bus.busy) busy_seen = 1'b1;
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL nomd_drain got %h want 0", bus.out_valid); end
    n_vec++; if (busy_seen) begin n_err++; $display("FAIL nomd_busy got 1 want 0"); end
  endtask
`endif

  initial begin
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_misc();
`ifdef EXEC_MULDIV_EN
    test_muldiv();
    test_reset_busy();
`else
    test_no_muldiv();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/execute_pipe.md
# execute_pipe

Registered, handshaked execute stage for the RV32I core, with optional multi-cycle unsigned multiply/divide. Each accepted operation produces an ALU result, the sequential PC (pc + PC_STEP) and a branch target (pc + imm). These are presented on an output register held stable under backpressure. It sits between decode/operand-fetch and memory-access; XLEN is parametrised.

## Interface
- XLEN, 32, datapath and PC width (≥ 8)
- PC_STEP, 4, constant added to pc_address for pc_plus_step
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation offered
- in_ready  out  1  stage can accept; transfer when in_valid && in_ready
- a, b  in  XLEN  operands
- alu_control  in  4  operation select
- pc_address  in  XLEN  PC of the instruction
- imm  in  XLEN  sign-extended immediate for branch target
- out_valid  out  1  result registers valid
- out_ready  in  1  consumer accepts; transfer when out_valid && out_ready
- alu_res_out  out  XLEN  result
- pc_plus_step  out  XLEN  pc_address + PC_STEP, modulo 2^XLEN
- branch_target  out  XLEN  pc_address + imm, modulo 2^XLEN
- busy  out  1  multi-cycle operation in progress

## Operation
- alu_control encoding:
  - 0 ADD; 1 SUB; 2 SLL; 3 SLT (signed); 4 SLTU; 5 XOR; 6 SRL; 7 SRA; 8 OR; 9 AND.
  - A MUL (low XLEN bits); B MULHU (high XLEN bits, unsigned); C DIVU; D REMU.
  - E, F reserved: result 0.
- Shift amount is b[log2(XLEN)-1:0]. SLT/SLTU produce 0 or 1, zero-extended. All arithmetic wraps modulo 2^XLEN.
- FSM states IDLE, BUSY, DONE. Reset state is IDLE.
- IDLE, single-cycle op accepted: results registered; go to DONE.
- IDLE, codes A–D accepted: operands and PC results latched; go to BUSY. busy=1.
- BUSY runs the iterative engine for exactly XLEN cycles, one bit per cycle:
  - Multiply: shift-add into a 2·XLEN product.
  - Divide: restoring shift-subtract.
  - Then result is registered; go to DONE.
- DONE: out_valid=1. On out_ready, go to IDLE. If in_valid is also high that cycle with a single-cycle op, accept it and stay in DONE (back-to-back).
- in_ready = (state==IDLE) || (state==DONE && out_ready).
- Divide by zero: DIVU returns all-ones; REMU returns a. Both take the full XLEN cycles.
- Outputs alu_res_out, pc_plus_step, branch_target hold their value while out_valid && !out_ready.
- Inputs are ignored when not transferred. Inputs may change freely during BUSY.

## Timing
- Reset values: in_ready=1 (after deassertion), out_valid=0, busy=0, alu_res_out=0, pc_plus_step=0, branch_target=0, FSM=IDLE, engine registers 0.
- rst_n is asserted asynchronously and deasserted synchronously to clk.
- Reset mid-BUSY aborts the operation. No output is produced for it.
- Single-cycle op: accepted at edge N; out_valid=1 after edge N. Throughput is 1 op/cycle with out_ready=1.
- Multi-cycle op: accepted at edge N; out_valid after edge N+XLEN+1. in_ready=0 from after edge N until DONE.
- in_ready has a combinational path from out_ready only. No combinational path from in_valid to any output.

## Configuration
- EXEC_MULDIV_EN defined: codes A–D are multi-cycle as above, and the BUSY state and engine are compiled in.
- EXEC_MULDIV_EN undefined: codes A–D behave as reserved. They produce result 0 with single-cycle latency. busy is tied 0, and no engine or BUSY logic is synthesised.

## Test plan
- Reset with rst_n=0 mid-stream -> all outputs at reset values immediately. First op after release: ADD a=5, b=7, pc=0x100, imm=0x20 -> alu_res_out=12, pc_plus_step=0x104, branch_target=0x120, one cycle later.
- Back-to-back with out_ready=1: SUB 3-5, SRA 0x80000000>>4, SLTU 1<2 -> 0xFFFFFFFE, 0xF8000000, 1 on consecutive cycles.
- Backpressure: out_ready=0 for 5 cycles after XOR 0xFF^0x0F -> 0xF0 held stable, in_ready=0. Release -> next op accepted the same cycle.
- With EXEC_MULDIV_EN:
  - MUL 0xFFFFFFFF×2 -> 0xFFFFFFFE.
  - MULHU same operands -> 1.
  - out_valid exactly 33 cycles after acceptance, busy high for 32 cycles.
- With EXEC_MULDIV_EN:
  - DIVU 100/7 -> 14; REMU -> 2.
  - DIVU x/0 -> 0xFFFFFFFF; REMU 9/0 -> 9.
  - Reset asserted during BUSY -> no out_valid.
- Without EXEC_MULDIV_EN: MUL 3×4 -> result 0 after 1 cycle, busy never asserted.
